// File: rtl/code_lock_pkg.sv
// Shared definitions for the serial code-entry controller.
//   CODE_W       width of an entered code (fixed by the downstream comparator)
//   DEFAULT_KEY  key restored on reset
//   state_e      controller state encoding
package code_lock_pkg;

   localparam int unsigned CODE_W  = 4;
   localparam int unsigned STATE_W = 3;

   localparam logic [CODE_W-1:0] DEFAULT_KEY = 4'b1011;

   typedef enum logic [STATE_W-1:0] {
      S_IDLE    = 3'd0,
      S_SHIFT   = 3'd1,
      S_CHECK   = 3'd2,
      S_UNLOCK  = 3'd3,
      S_FAIL    = 3'd4,
      S_LOCKOUT = 3'd5
   } state_e;

endpackage

// File: rtl/code_shift_in.sv
// Serial MSB-first shift register with bit counter.
//   clk, rst_n  clock and async active-low reset
//   first       the next accepted bit starts a new code (clears the register)
//   accept      the controller is in a state that takes bits
//   bit_valid   bit_in is offered on this edge
//   bit_in      serial data bit
//   data        assembled code (holds until the next code starts)
//   done_c      the bit taken on this edge completes the code
module code_shift_in
   import code_lock_pkg::*;
#(
   parameter int unsigned CODE_W = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              first,
   input  logic              accept,
   input  logic              bit_valid,
   input  logic              bit_in,
   output logic [CODE_W-1:0] data,
   output logic              done_c
);

   localparam int unsigned CNT_W = $clog2(CODE_W + 1);

   logic [CNT_W-1:0] count;
   logic             take_c;

   assign take_c = accept && bit_valid;

   // Completion is flagged on the same edge that takes the last bit so the
   // controller can move to its compare state without an idle cycle.
   assign done_c = take_c && !first && (count == CNT_W'(CODE_W - 1));

   // Shift register and bit counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data  <= '0;
         count <= '0;
      end else if (take_c) begin
         if (first) begin
            data  <= {(CODE_W-1)'(0), bit_in};
            count <= CNT_W'(1);
         end else begin
            data  <= {data[CODE_W-2:0], bit_in};
            count <= count + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/code_entry_fsm.sv
// Serial code-entry controller. Collects a code bit by bit, presents it with
// the stored key to an external comparator, reacts to the comparator's
// equality flag with unlock/fail pulses and enforces a timed lockout after
// MAX_TRIES consecutive mismatches.
//   clk, rst_n  clock and async active-low reset
//   bit_in      serial code bit, MSB first; bit_valid qualifies it
//   key_load    load key_in as the stored key (honoured in IDLE only)
//   match_flag  comparator equality of entered vs key
//   entered     code being / last entered (comparator input a1)
//   key         stored key (comparator input a2)
//   unlock      one-cycle pulse on a match
//   fail        one-cycle pulse on every mismatch
//   locked      high for the whole lockout
//   busy        high whenever not idle
module code_entry_fsm
   import code_lock_pkg::*;
#(
   parameter int unsigned CODE_W      = 4,
   parameter int unsigned MAX_TRIES   = 3,
   parameter int unsigned LOCK_CYCLES = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              bit_in,
   input  logic              bit_valid,
   input  logic              key_load,
   input  logic [CODE_W-1:0] key_in,
   input  logic              match_flag,
   output logic [CODE_W-1:0] entered,
   output logic [CODE_W-1:0] key,
   output logic              unlock,
   output logic              fail,
   output logic              locked,
   output logic              busy
);

   localparam int unsigned TRY_W  = 3;
   localparam int unsigned LOCK_W = $clog2(LOCK_CYCLES + 1);

   localparam logic [STATE_W-1:0] ST_IDLE    = S_IDLE;
   localparam logic [STATE_W-1:0] ST_SHIFT   = S_SHIFT;
   localparam logic [STATE_W-1:0] ST_CHECK   = S_CHECK;
   localparam logic [STATE_W-1:0] ST_UNLOCK  = S_UNLOCK;
   localparam logic [STATE_W-1:0] ST_FAIL    = S_FAIL;
   localparam logic [STATE_W-1:0] ST_LOCKOUT = S_LOCKOUT;

   logic [STATE_W-1:0] state_q, state_d;
   logic [TRY_W-1:0]   tries_q, tries_d;
   logic [LOCK_W-1:0]  lock_q,  lock_d;
   logic [CODE_W-1:0]  key_d;
   logic               first_c;
   logic               accept_c;
   logic               done_c;

   // Bits are only taken in IDLE (starting a code) and SHIFT
   assign first_c  = (state_q == ST_IDLE);
   assign accept_c = (state_q == ST_IDLE) || (state_q == ST_SHIFT);

   code_shift_in #(
      .CODE_W (CODE_W)
   ) u_shift (
      .clk       (clk),
      .rst_n     (rst_n),
      .first     (first_c),
      .accept    (accept_c),
      .bit_valid (bit_valid),
      .bit_in    (bit_in),
      .data      (entered),
      .done_c    (done_c)
   );

   // Next-state, try counter, lockout counter and key update
   always_comb begin
      state_d = state_q;
      tries_d = tries_q;
      lock_d  = lock_q;
      key_d   = key;
      case (state_q)
         ST_IDLE: begin
            // A bit in the same cycle as key_load wins; the load is dropped
            if (bit_valid) begin
               state_d = ST_SHIFT;
            end else if (key_load) begin
               key_d = key_in;
            end
         end
         ST_SHIFT: begin
            if (done_c) begin
               state_d = ST_CHECK;
            end
         end
         ST_CHECK: begin
            if (match_flag) begin
               tries_d = '0;
               state_d = ST_UNLOCK;
            end else begin
               if (tries_q < TRY_W'(MAX_TRIES)) begin
                  tries_d = tries_q + TRY_W'(1);
               end
               state_d = ST_FAIL;
            end
         end
         ST_UNLOCK: begin
            state_d = ST_IDLE;
         end
         ST_FAIL: begin
            if (tries_q == TRY_W'(MAX_TRIES)) begin
               lock_d  = LOCK_W'(LOCK_CYCLES - 1);
               state_d = ST_LOCKOUT;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_LOCKOUT: begin
            if (lock_q == '0) begin
               tries_d = '0;
               state_d = ST_IDLE;
            end else begin
               lock_d = lock_q - LOCK_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and registered Moore outputs (derived from the next state so each
   // output is high exactly while the matching state is current)
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         tries_q <= '0;
         lock_q  <= '0;
         key     <= CODE_W'(DEFAULT_KEY);
         unlock  <= 1'b0;
         fail    <= 1'b0;
         locked  <= 1'b0;
         busy    <= 1'b0;
      end else begin
         state_q <= state_d;
         tries_q <= tries_d;
         lock_q  <= lock_d;
         key     <= key_d;
         unlock  <= (state_d == ST_UNLOCK);
         fail    <= (state_d == ST_FAIL);
         locked  <= (state_d == ST_LOCKOUT);
         busy    <= (state_d != ST_IDLE);
      end
   end

endmodule

// File: tb/tb_code_entry_fsm.sv
// Testbench for code_entry_fsm: directed and randomized entries checked
// against an entry-level model (key, consecutive-mismatch count, lockout).
module tb_code_entry_fsm;

   localparam int unsigned CODE_W      = 4;
   localparam int unsigned MAX_TRIES   = 3;
   localparam int unsigned LOCK_CYCLES = 16;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              bit_in = 1'b0;
   logic              bit_valid = 1'b0;
   logic              key_load = 1'b0;
   logic [CODE_W-1:0] key_in = '0;
   logic              match_flag;
   logic [CODE_W-1:0] entered;
   logic [CODE_W-1:0] key;
   logic              unlock;
   logic              fail;
   logic              locked;
   logic              busy;

   int n_checks = 0;
   int n_fail   = 0;

   // Model state: current key and consecutive mismatches
   logic [CODE_W-1:0] key_m;
   int                tries_m;

   always #5 clk = ~clk;

   // External combinational comparator
   assign match_flag = (entered == key);

   code_entry_fsm #(
      .CODE_W      (CODE_W),
      .MAX_TRIES   (MAX_TRIES),
      .LOCK_CYCLES (LOCK_CYCLES)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bit_in     (bit_in),
      .bit_valid  (bit_valid),
      .key_load   (key_load),
      .key_in     (key_in),
      .match_flag (match_flag),
      .entered    (entered),
      .key        (key),
      .unlock     (unlock),
      .fail       (fail),
      .locked     (locked),
      .busy       (busy)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_entered"}, 32'(entered), 32'(0));
      check({tag, "_key"},     32'(key),     32'(4'b1011));
      check({tag, "_unlock"},  32'(unlock),  32'(0));
      check({tag, "_fail"},    32'(fail),    32'(0));
      check({tag, "_locked"},  32'(locked),  32'(0));
      check({tag, "_busy"},    32'(busy),    32'(0));
   endtask

   // Asynchronous reset applied mid-cycle, outputs checked before any edge
   task automatic async_reset(input string tag);
      bit_valid = 1'b0;
      key_load  = 1'b0;
      #2 rst_n = 1'b0;
      #1 check_reset_vals(tag);
      key_m   = 4'b1011;
      tries_m = 0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic load_key(input logic [CODE_W-1:0] k);
      @(negedge clk);
      key_load = 1'b1;
      key_in   = k;
      @(negedge clk);
      key_load = 1'b0;
      key_m    = k;
      check("key_load", 32'(key), 32'(k));
   endtask

   // One full entry; rst_at>0 resets after that many lockout cycles
   task automatic run_entry(input logic [CODE_W-1:0] code, input int rst_at);
      logic exp_match;
      logic exp_lock;
      int   n;
      for (int i = CODE_W - 1; i >= 0; i--) begin
         @(negedge clk);
         if (i < int'(CODE_W) - 1) begin
            // Gaps inside the entry, with key_load noise that must be ignored
            repeat ($urandom_range(0, 2)) begin
               bit_valid = 1'b0;
               bit_in    = 1'($urandom);
               key_load  = 1'($urandom);
               key_in    = CODE_W'($urandom);
               @(negedge clk);
            end
         end
         bit_valid = 1'b1;
         bit_in    = code[i];
         key_load  = 1'b0;
         if (i == int'(CODE_W) - 1 && $urandom_range(0, 2) == 0) begin
            // Simultaneous key_load in IDLE loses to the bit
            key_load = 1'b1;
            key_in   = ~key_m;
         end
      end
      @(negedge clk);
      bit_valid = 1'b0;
      key_load  = 1'b0;
      check("check_busy",    32'(busy),    32'(1));
      check("check_pulse",   32'({unlock, fail}), 32'(0));
      check("check_entered", 32'(entered), 32'(code));

      exp_match = (code == key_m);
      if (exp_match) tries_m = 0;
      else if (tries_m < int'(MAX_TRIES)) tries_m++;
      exp_lock = !exp_match && (tries_m == int'(MAX_TRIES));

      bit_valid = 1'b1;
      bit_in    = ~code[CODE_W-1];
      @(negedge clk);
      check("unlock", 32'(unlock), 32'(exp_match));
      check("fail",   32'(fail),   32'(!exp_match));
      check("pulse_busy", 32'(busy), 32'(1));
      @(negedge clk);
      bit_valid = 1'b0;
      check("entered_hold", 32'(entered), 32'(code));
      check("key_kept",     32'(key),     32'(key_m));
      check("lock_start",   32'(locked),  32'(exp_lock));
      check("pulse_end",    32'({unlock, fail}), 32'(0));
      if (exp_lock) begin
         n = 0;
         while (locked === 1'b1 && n < 200) begin
            n++;
            bit_valid = 1'($urandom);
            bit_in    = 1'($urandom);
            if (rst_at != 0 && n == rst_at) begin
               async_reset("lock_rst");
               return;
            end
            @(negedge clk);
         end
         bit_valid = 1'b0;
         check("lock_len",      32'(n),       32'(LOCK_CYCLES));
         check("lock_entered",  32'(entered), 32'(code));
         tries_m = 0;
      end
      check("idle_busy",   32'(busy),   32'(0));
      check("idle_locked", 32'(locked), 32'(0));
   endtask

   initial begin
      key_m   = 4'b1011;
      tries_m = 0;

      repeat (2) @(negedge clk);
      check_reset_vals("por");
      rst_n = 1'b1;

      // Default key, then a single mismatch
      run_entry(4'b1011, 0);
      run_entry(4'b1101, 0);

      // Clear tries, then three consecutive mismatches lock out
      run_entry(4'b1011, 0);
      run_entry(4'b1101, 0);
      run_entry(4'b1001, 0);
      run_entry(4'b0000, 0);

      // New key and match against it
      load_key(4'b0110);
      run_entry(4'b0110, 0);

      // A match clears tries; two further mismatches do not lock
      run_entry(4'b1111, 0);
      run_entry(4'b0001, 0);
      run_entry(4'b0110, 0);
      run_entry(4'b1000, 0);
      run_entry(4'b0111, 0);

      // Randomized entries and key changes
      for (int r = 0; r < 24; r++) begin
         if ($urandom_range(0, 5) == 0) load_key(CODE_W'($urandom));
         if ($urandom_range(0, 2) == 0) run_entry(key_m, 0);
         else                           run_entry(CODE_W'($urandom), 0);
      end

      // Reset mid-entry restores the default key
      load_key(4'b0101);
      run_entry(4'b0101, 0);
      @(negedge clk);
      bit_valid = 1'b1;
      bit_in    = 1'b1;
      @(negedge clk);
      bit_in    = 1'b0;
      @(negedge clk);
      bit_valid = 1'b0;
      check("mid_entered", 32'(entered), 32'(4'b0010));
      check("mid_busy",    32'(busy),    32'(1));
      async_reset("entry_rst");
      run_entry(4'b1011, 0);

      // Reset during lockout
      load_key(4'b0011);
      run_entry(4'b1100, 0);
      run_entry(4'b1110, 0);
      run_entry(4'b0111, 5);
      run_entry(4'b1011, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
